// File: rtl/rv32_pkg.sv
// rv32_pkg: ALUSel codes, R-type field constants, FSM states and the R-type encode/legality helpers
package rv32_pkg;
  localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3, ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7, ALU_OR = 4'd8, ALU_AND = 4'd9;
  localparam logic [6:0] OPCODE_OP = 7'b0110011;
  localparam logic [2:0] F3_ADD_SUB = 3'b000, F3_SLL = 3'b001, F3_SLT = 3'b010, F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR = 3'b100, F3_SRL_SRA = 3'b101, F3_OR = 3'b110, F3_AND = 3'b111;
  localparam logic [6:0] F7_BASE = 7'b0000000, F7_ALT = 7'b0100000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, TERM} state_e;
  function automatic logic op_legal(input logic [3:0] op);
    return op <= ALU_AND;
  endfunction
  function automatic logic [31:0] encode(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
    logic [2:0] f3;
    logic [6:0] f7;
    f3 = op == ALU_SLL  ? F3_SLL  :
         op == ALU_SLT  ? F3_SLT  :
         op == ALU_SLTU ? F3_SLTU :
         op == ALU_XOR  ? F3_XOR  :
         (op == ALU_SRL || op == ALU_SRA) ? F3_SRL_SRA :
         op == ALU_OR   ? F3_OR   :
         op == ALU_AND  ? F3_AND  : F3_ADD_SUB;
    f7 = (op == ALU_SUB || op == ALU_SRA) ? F7_ALT : F7_BASE;
    return {f7, rs2, rs1, f3, rd, OPCODE_OP};
  endfunction
endpackage

// File: rtl/rv32_sync_fifo.sv
// rv32_sync_fifo: W-bit x DEPTH sync FIFO; ports i_clk, i_rst_n, i_push/i_data, i_pop/o_data(head), o_full, o_empty
module rv32_sync_fifo #(
  parameter int W = 32,
  parameter int DEPTH = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty
);
  localparam int PW = $clog2(DEPTH);
  logic [PW:0] wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  logic [W-1:0] mem_d [DEPTH];
  logic push_ok, pop_ok;
  assign o_empty = wr_q == rd_q;
  assign o_full = (wr_q[PW] != rd_q[PW]) && (wr_q[PW-1:0] == rd_q[PW-1:0]);
  assign o_data = mem_q[rd_q[PW-1:0]];
  assign push_ok = i_push && !o_full;
  assign pop_ok = i_pop && !o_empty;
  always_comb begin
    mem_d = mem_q;
    wr_d = wr_q + (PW+1)'(push_ok);
    rd_d = rd_q + (PW+1)'(pop_ok);
    if (push_ok) mem_d[wr_q[PW-1:0]] = i_data;
  end
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
    if (!i_rst_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
endmodule

// File: rtl/rv32_rtype_encoder.sv
// rv32_rtype_encoder: ALU requests (i_valid/o_ready, i_op, i_rd/i_rs1/i_rs2, i_last) -> R-type words written to imem (o_mem_we/addr/wdata, i_mem_ready); status o_busy/o_done/o_count/o_err; RV32_ENC_ILLEGAL_TRAP_EN drops ops > 9 and sets o_err
module rv32_rtype_encoder
  import rv32_pkg::*;
#(
  parameter int          AW = 10,
  parameter int          DEPTH = 4,
  parameter int unsigned BASE_ADDR = 0,
  parameter bit          TERMINATE = 1'b1
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_start,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [3:0]    i_op,
  input  logic [4:0]    i_rd,
  input  logic [4:0]    i_rs1,
  input  logic [4:0]    i_rs2,
  input  logic          i_last,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [31:0]   o_mem_wdata,
  input  logic          i_mem_ready,
  output logic          o_busy,
  output logic          o_done,
  output logic [AW-3:0] o_count,
  output logic          o_err
);
  localparam int CW = AW - 2;
  state_e state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [CW-1:0] count_q, count_d;
  logic done_q, done_d;
  logic fifo_full, fifo_empty, accept, legal, streaming, wr_ok;
  logic [31:0] head;
  assign streaming = state_q == LOAD || state_q == DRAIN;
  assign o_ready = state_q == LOAD && !fifo_full;
  assign accept = i_valid && o_ready;
  assign o_mem_we = (streaming && !fifo_empty) || state_q == TERM;
  assign wr_ok = o_mem_we && i_mem_ready;
  assign o_mem_addr = o_mem_we ? addr_q : '0;
  assign o_mem_wdata = state_q == TERM ? NOP_WORD : (o_mem_we ? head : '0);
  assign o_busy = state_q != IDLE;
  assign o_done = done_q;
  assign o_count = count_q;
`ifdef RV32_ENC_ILLEGAL_TRAP_EN
  logic err_q, err_d;
  assign legal = op_legal(i_op);
  assign err_d = err_q || (accept && !legal);
  assign o_err = err_q;
  always_ff @(posedge i_clk) err_q <= i_rst_n ? err_d : 1'b0;
`else
  assign legal = 1'b1;
  assign o_err = 1'b0;
`endif
  rv32_sync_fifo #(.W(32), .DEPTH(DEPTH)) u_fifo (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_push (accept && legal),
    .i_data (encode(i_op, i_rd, i_rs1, i_rs2)),
    .i_pop  (streaming && wr_ok),
    .o_data (head),
    .o_full (fifo_full),
    .o_empty(fifo_empty)
  );
  always_comb begin
    state_d = state_q;
    addr_d = wr_ok ? addr_q + AW'(4) : addr_q;
    count_d = wr_ok ? count_q + CW'(1) : count_q;
    done_d = 1'b0;
    if (state_q == IDLE && i_start) begin
      state_d = LOAD;
      addr_d = AW'(BASE_ADDR);
      count_d = '0;
    end
    if (state_q == LOAD && accept && i_last) state_d = DRAIN;
    if (state_q == DRAIN && fifo_empty) begin
      state_d = TERMINATE ? TERM : IDLE;
      done_d = !TERMINATE;
    end
    if (state_q == TERM && i_mem_ready) begin
      state_d = IDLE;
      done_d = 1'b1;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      addr_q <= AW'(BASE_ADDR);
      count_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      count_q <= count_d;
      done_q <= done_d;
    end
  end
endmodule

// File: tb/tb_rv32_rtype_encoder.sv
// tb_rv32_rtype_encoder: random and directed programs on a default and a small wrapping encoder, checked against an arithmetic reference
module tb_rv32_rtype_encoder;
  logic i_clk = 0, i_rst_n = 0, i_start = 0, i_valid = 0, i_last = 0, i_mem_ready = 0;
  logic [3:0] i_op = 0;
  logic [4:0] i_rd = 0, i_rs1 = 0, i_rs2 = 0;
  logic a_ready, a_we, a_busy, a_done, a_err, b_ready, b_we, b_busy, b_done, b_err;
  logic [9:0] a_addr;
  logic [3:0] b_addr;
  logic [31:0] a_wdata, b_wdata;
  logic [7:0] a_count;
  logic [1:0] b_count;
  int n_chk = 0, n_pass = 0, rdy_mode = 0;
  bit exp_err = 0;
  logic [31:0] exp_q[$], got_a_data[$], got_b_data[$];
  int got_a_addr[$], got_b_addr[$];
  int f3_tab[10] = '{0, 0, 1, 2, 3, 4, 5, 5, 6, 7};

  rv32_rtype_encoder u_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid), .o_ready(a_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_last(i_last),
    .o_mem_we(a_we), .o_mem_addr(a_addr), .o_mem_wdata(a_wdata), .i_mem_ready(i_mem_ready),
    .o_busy(a_busy), .o_done(a_done), .o_count(a_count), .o_err(a_err)
  );
  rv32_rtype_encoder #(.AW(4), .DEPTH(4), .BASE_ADDR(12), .TERMINATE(1'b1)) u_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_valid(i_valid), .o_ready(b_ready),
    .i_op(i_op), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_last(i_last),
    .o_mem_we(b_we), .o_mem_addr(b_addr), .o_mem_wdata(b_wdata), .i_mem_ready(i_mem_ready),
    .o_busy(b_busy), .o_done(b_done), .o_count(b_count), .o_err(b_err)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) begin
    #1;
    i_mem_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? 1'($urandom % 2) : 1'b0;
  end
  always @(negedge i_clk) begin
    if (i_rst_n && a_we && i_mem_ready) begin
      got_a_data.push_back(a_wdata);
      got_a_addr.push_back(int'(a_addr));
    end
    if (i_rst_n && b_we && i_mem_ready) begin
      got_b_data.push_back(b_wdata);
      got_b_addr.push_back(int'(b_addr));
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%h exp=%h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [31:0] ref_word(input int op, input int rd, input int rs1, input int rs2);
    int o;
    o = op > 9 ? 0 : op;
    return 32'(((o == 1 || o == 7) ? 32 : 0) * 33554432 + rs2 * 1048576 + rs1 * 32768 +
               f3_tab[o] * 4096 + rd * 128 + 51);
  endfunction

  function automatic logic [31:0] got_word(input int i);
    return i < got_a_data.size() ? got_a_data[i] : 32'hdead_beef;
  endfunction

  task automatic start_prog();
    for (int k = 0; k < 200 && a_busy; k++) @(posedge i_clk) #1;
    got_a_data.delete(); got_a_addr.delete(); got_b_data.delete(); got_b_addr.delete();
    exp_q.delete();
    i_start = 1;
    @(posedge i_clk) #1;
    i_start = 0;
  endtask

  task automatic send(input int op, input int rd, input int rs1, input int rs2, input bit last);
    bit acc = 0;
    i_valid = 1; i_op = 4'(op); i_rd = 5'(rd); i_rs1 = 5'(rs1); i_rs2 = 5'(rs2); i_last = last;
    for (int k = 0; k < 300; k++) begin
      @(negedge i_clk);
      if (a_ready) begin
        acc = 1;
        break;
      end
    end
    @(posedge i_clk) #1;
    i_valid = 0; i_last = 0;
    if (!acc) check("send_timeout", 0, 1);
`ifdef RV32_ENC_ILLEGAL_TRAP_EN
    if (acc && op > 9) exp_err = 1;
    else if (acc) exp_q.push_back(ref_word(op, rd, rs1, rs2));
`else
    if (acc) exp_q.push_back(ref_word(op, rd, rs1, rs2));
`endif
    if (acc && last) begin
      @(negedge i_clk);
      check("rdy_after_last", a_ready, 0);
      @(posedge i_clk) #1;
    end
  endtask

  task automatic finish_prog();
    bit seen = 0;
    exp_q.push_back(32'h0000_0013);
    for (int k = 0; k < 3000; k++) begin
      @(negedge i_clk);
      if (a_done) begin
        seen = 1;
        break;
      end
    end
    check("done", seen, 1);
    check("doneB", b_done, 1);
    check("idle_after_done", a_busy, 0);
    check("nwords", got_a_data.size(), exp_q.size());
    check("nwordsB", got_b_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_a_data.size()) begin
        check("wdata", got_a_data[i], exp_q[i]);
        check("addr", got_a_addr[i], (4 * i) % 1024);
      end
      if (i < got_b_data.size()) begin
        check("wdataB", got_b_data[i], exp_q[i]);
        check("addrB_wrap", got_b_addr[i], (12 + 4 * i) % 16);
      end
    end
    check("count", a_count, exp_q.size() % 256);
    check("countB", b_count, exp_q.size() % 4);
    check("err", a_err, exp_err);
    @(negedge i_clk);
    check("done_1cyc", a_done, 0);
    @(posedge i_clk) #1;
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    check("rst_we", a_we, 0); check("rst_addr", a_addr, 0); check("rst_addrB", b_addr, 0);
    check("rst_wdata", a_wdata, 0); check("rst_ready", a_ready, 0); check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0); check("rst_count", a_count, 0); check("rst_err", a_err, 0);
    @(posedge i_clk) #1;
    i_rst_n = 1;
    i_valid = 1; i_op = 4'd5; i_last = 1;
    repeat (4) @(negedge i_clk);
    check("idle_ready", a_ready, 0);
    check("idle_nowrite", got_a_data.size(), 0);
    @(posedge i_clk) #1;
    i_valid = 0; i_last = 0;
    start_prog();
    send(0, 3, 1, 2, 1);
    finish_prog();
    check("tp_add", got_word(0), 32'h0020_81B3);
    check("tp_nop", got_word(1), 32'h0000_0013);
    start_prog();
    send(1, 5, 6, 7, 0);
    i_start = 1;
    @(posedge i_clk) #1;
    i_start = 0;
    send(7, 10, 11, 12, 0);
    send(9, 1, 2, 3, 1);
    finish_prog();
    check("tp_sub", got_word(0), 32'h4073_02B3);
    check("tp_sra", got_word(1), 32'h40C5_D533);
    check("tp_and", got_word(2), 32'h0031_70B3);
    rdy_mode = 2;
    start_prog();
    for (int j = 0; j < 4; j++) send(j + 2, j + 1, j + 9, j + 17, 0);
    i_valid = 1; i_op = 4'd6; i_rd = 5'd20; i_rs1 = 5'd21; i_rs2 = 5'd22;
    @(negedge i_clk);
    check("rdy_full", a_ready, 0);
    check("stall_we", a_we, 1);
    check("stall_wdata", a_wdata, exp_q[0]);
    check("stall_addr", a_addr, 0);
    repeat (15) @(negedge i_clk);
    check("stall_wdata_hold", a_wdata, exp_q[0]);
    check("stall_addr_hold", a_addr, 0);
    check("stall_nowrite", got_a_data.size(), 0);
    rdy_mode = 0;
    @(negedge i_clk);
    check("rdy_full_pop", a_ready, 0);
    @(posedge i_clk) #1;
    send(6, 20, 21, 22, 0);
    send(8, 23, 24, 25, 1);
    finish_prog();
    rdy_mode = 2;
    start_prog();
    send(3, 4, 5, 6, 0);
    send(4, 7, 8, 9, 0);
    send(5, 10, 11, 12, 1);
    check("drain_busy", a_busy, 1);
    check("drain_we", a_we, 1);
    i_rst_n = 0;
    @(posedge i_clk) #1;
    exp_err = 0;
    check("mid_rst_we", a_we, 0); check("mid_rst_addr", a_addr, 0); check("mid_rst_wdata", a_wdata, 0);
    check("mid_rst_busy", a_busy, 0); check("mid_rst_count", a_count, 0); check("mid_rst_ready", a_ready, 0);
    check("mid_rst_done", a_done, 0); check("mid_rst_weB", b_we, 0);
    i_rst_n = 1;
    rdy_mode = 0;
    start_prog();
    send(2, 30, 31, 1, 1);
    finish_prog();
    start_prog();
    send(0, 1, 2, 3, 0);
    send(12, 4, 5, 6, 0);
    send(5, 7, 8, 9, 1);
    finish_prog();
    start_prog();
    send(15, 11, 12, 13, 1);
    finish_prog();
    for (int p = 0; p < 10; p++) begin
      int n;
      rdy_mode = int'($urandom % 2);
      n = int'($urandom_range(1, 7));
      start_prog();
      for (int j = 0; j < n; j++)
        send(int'($urandom_range(0, 11)), int'($urandom % 32), int'($urandom % 32), int'($urandom % 32), j == n - 1);
      finish_prog();
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
